// File: rtl/cpu_pkg.sv
// Shared CPU constants: machine widths, instruction field positions, opcodes
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W  = 5;
    localparam int INSTR_W = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int TGT_MSB = 26;
    localparam int TGT_LSB = 22;

    localparam logic [OPC_MSB-OPC_LSB:0] OPC_JUMP = 5'b10001;
    localparam logic [OPC_MSB-OPC_LSB:0] OPC_HALT = 5'b10000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output register between fetch and decode.
// A flush drops the held entry even when decode is not accepting.
module fetch_out_reg #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= load_instr;
            out_pc    <= load_pc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, resolves jumps, stops on halt and
// accepts redirects. Define FETCH_PERF_CNT_EN to add fetch/stall counters.
module fetch_unit #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt,
`endif
    output logic               halted,
    output logic               busy
);

    import cpu_pkg::*;

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;

    logic [OPC_MSB-OPC_LSB:0] opcode;
    logic [ADDR_W-1:0]        target;
    logic                     is_jump, is_halt;
    logic                     slot_free, fire, flush, load;

    assign imem_addr = pc;
    assign opcode    = imem_data[OPC_MSB:OPC_LSB];
    assign target    = ADDR_W'(imem_data[TGT_MSB:TGT_LSB]);
    assign is_jump   = (opcode == OPC_JUMP);
    assign is_halt   = (opcode == OPC_HALT);

    assign slot_free = !out_valid || out_ready;
    assign fire      = (state == FETCH) && slot_free && !redirect_valid;
    assign flush     = redirect_valid && (state != IDLE);
    // Jump words are consumed here and never reach decode.
    assign load      = fire && !is_jump;

    assign busy   = (state == FETCH);
    assign halted = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // NOTE: hold values are assigned first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        unique case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end else if (fire) begin
                    if (is_jump)      pc_next    = target;
                    else if (is_halt) state_next = HALTED;
                    else              pc_next    = pc + ADDR_W'(1);
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (start) begin
                    pc_next    = RESET_PC;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    fetch_out_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .load_instr(imem_data),
        .load_pc   (pc),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic stall;
    assign stall = (state == FETCH) && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (start) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (load && perf_fetch_cnt != 16'hFFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if (stall && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// programs compared against a program-walk model of the delivered stream.
module tb_fetch_unit;

    localparam int AW = 5;
    localparam int IW = 32;
    localparam logic [31:0] HALT_W = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] imem_addr, out_pc;
    logic [IW-1:0] imem_data, out_instr;
    logic          out_valid, halted, busy;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]   perf_fetch_cnt, perf_stall_cnt;
`endif

    logic [IW-1:0] mem [32];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .halted        (halted),
        .busy          (busy)
    );

    int n_errors = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int pc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"}, 32'(out_pc), 32'(pc));
        check({tag, "_instr"}, out_instr, mem[pc]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] jump_word(input int tgt);
        logic [4:0] t;
        t = 5'(tgt);
        return {5'b10001, t, 22'h0};
    endfunction

    // Reference model: the ordered (pc, word) stream decode should receive
    int          exp_pc[$];
    logic [31:0] exp_instr[$];
    bit          exp_halt_end;

    task automatic walk_program(input int max_items);
        int   pc;
        logic [4:0] op;
        exp_pc.delete();
        exp_instr.delete();
        exp_halt_end = 1'b0;
        pc = 0;
        for (int step = 0; step < 400 && exp_pc.size() < max_items; step++) begin
            op = mem[pc][31:27];
            if (op == 5'b10001) begin
                pc = int'(mem[pc][26:22]);
            end else begin
                exp_pc.push_back(pc);
                exp_instr.push_back(mem[pc]);
                if (op == 5'b10000) begin
                    exp_halt_end = 1'b1;
                    break;
                end
                pc = (pc + 1) % 32;
            end
        end
    endtask

    initial begin
        int          accepted, stalls, cycles, kind;
        bit          hold;
        logic [AW-1:0] hold_pc;
        logic [IW-1:0] hold_instr, w;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[4] = HALT_W;

        // Reset state
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Straight-line run to HALT
        out_ready = 1'b1;
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_out("seq", k);
            check("seq_halted", 32'(halted), (k == 4) ? 32'd1 : 32'd0);
        end
        check("halt_addr", 32'(imem_addr), 32'd4);
        tick();
        check("halt_hold_addr", 32'(imem_addr), 32'd4);
        check("halt_drained", 32'(out_valid), 32'd0);
        check("halt_busy", 32'(busy), 32'd0);

        // Backpressure at pc 2
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("bp_pre", k);
        end
        check("bp_addr", 32'(imem_addr), 32'd3);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("bp_stall", 2);
            check("bp_stall_addr", 32'(imem_addr), 32'd3);
        end
        out_ready = 1'b1;
        tick();
        expect_out("bp_post", 3);
        tick();
        expect_out("bp_post", 4);
        check("bp_halted", 32'(halted), 32'd1);

        // Jump at 5 to 20 costs one bubble
        mem[4]  = 32'h0000_0004;
        mem[5]  = jump_word(20);
        mem[20] = 32'h1234_5678;
        mem[21] = HALT_W;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_out("jmp_pre", k);
        end
        tick();
        check("jmp_bubble", 32'(out_valid), 32'd0);
        check("jmp_addr", 32'(imem_addr), 32'd20);
        tick();
        expect_out("jmp_tgt", 20);
        tick();
        expect_out("jmp_halt", 21);
        check("jmp_halted", 32'(halted), 32'd1);

        // Redirect to 30 and wrap past 31
        mem[30] = 32'h0A0A_0030;
        mem[31] = 32'h0B0B_0031;
        mem[7]  = 32'h0C0C_0007;
        mem[8]  = 32'h0000_0008;
        mem[9]  = HALT_W;
        redirect_valid = 1'b1;
        redirect_pc    = 5'd30;
        tick();
        redirect_valid = 1'b0;
        check("wrap_busy", 32'(busy), 32'd1);
        check("wrap_flush", 32'(out_valid), 32'd0);
        tick();
        expect_out("wrap", 30);
        tick();
        expect_out("wrap", 31);
        tick();
        expect_out("wrap", 0);

        // Redirect flushes a stalled entry
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 5'd7;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        expect_out("redir", 7);
        tick();
        expect_out("redir", 8);
        tick();
        expect_out("redir", 9);
        check("redir_halted", 32'(halted), 32'd1);

        // Redirect beats start while halted
        start          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 5'd7;
        tick();
        start          = 1'b0;
        redirect_valid = 1'b0;
        check("prio_addr", 32'(imem_addr), 32'd7);
        check("prio_busy", 32'(busy), 32'd1);
        check("prio_valid", 32'(out_valid), 32'd0);
        tick();
        expect_out("prio", 7);

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_instr", out_instr, 32'd0);
        check("arst_pc", 32'(out_pc), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("arst_perf_fetch", 32'(perf_fetch_cnt), 32'd0);
        check("arst_perf_stall", 32'(perf_stall_cnt), 32'd0);
`endif
        tick();

        // Random programs with random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                w    = $urandom;
                kind = $urandom_range(0, 15);
                if (kind == 0)      w = {5'b10000, w[26:0]};
                else if (kind < 3)  w = {5'b10001, w[26:0]};
                else if (w[31:28] == 4'b1000) w[31] = 1'b0;
                mem[i] = w;
            end
            walk_program(40);

            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            out_ready = 1'b0;
            pulse_start();

            accepted = 0;
            stalls   = 0;
            cycles   = 0;
            hold     = 1'b0;
            while (cycles < 3000 && accepted < exp_pc.size()) begin
                out_ready = ($urandom_range(0, 99) < 60);
                if (hold) begin
                    check("rnd_hold_valid", 32'(out_valid), 32'd1);
                    check("rnd_hold_pc", 32'(out_pc), 32'(hold_pc));
                    check("rnd_hold_instr", out_instr, hold_instr);
                end
                if (out_valid && out_ready) begin
                    check("rnd_pc", 32'(out_pc), 32'(exp_pc[accepted]));
                    check("rnd_instr", out_instr, exp_instr[accepted]);
                    accepted++;
                end
                if (busy && out_valid && !out_ready) stalls++;
                hold       = out_valid && !out_ready;
                hold_pc    = out_pc;
                hold_instr = out_instr;
                tick();
                cycles++;
            end
            check("rnd_count", 32'(accepted), 32'(exp_pc.size()));
            if (exp_halt_end) check("rnd_halted", 32'(halted), 32'd1);
`ifdef FETCH_PERF_CNT_EN
            check("rnd_perf_fetch", 32'(perf_fetch_cnt), 32'(accepted + int'(out_valid)));
            check("rnd_perf_stall", 32'(perf_stall_cnt), 32'(stalls));
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
